sweep_ctrl: RTL and testbench
=============================

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter SHALL be: DWELL_W, 16, width of the dwell counter and of cfg_dwell.
REQ-002 clk  in  1  clock; all logic SHALL be rising-edge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cfg_valid  in  1  load cfg_start/cfg_stop/cfg_step/cfg_dwell when cfg_ready=1.
REQ-005 cfg_ready  out  1  high in IDLE and LOADED.
REQ-006 cfg_start  in  32  first frequency control word of the sweep.
REQ-007 cfg_stop  in  32  terminal frequency control word (unsigned).
REQ-008 cfg_step  in  32  unsigned increment between successive words.
REQ-009 cfg_dwell  in  DWELL_W  each word held cfg_dwell+1 cycles.
REQ-010 go  in  1  start a sweep from LOADED.
REQ-011 abort  in  1  terminate a running sweep.
REQ-012 ctrl  out  32  frequency control word to the sawtooth generator; registered.
REQ-013 gen_rst  out  1  one-cycle phase reset to the generator at sweep start.
REQ-014 busy  out  1  high while the sweep runs.
REQ-015 done  out  1  one-cycle pulse on normal sweep completion.

Function
REQ-016 States SHALL be IDLE, LOADED, RUN_UP, RUN_DN (macro only), FIN.
REQ-017 IDLE: cfg_valid SHALL latch config and go to LOADED; go and abort ignored.
REQ-018 LOADED: cfg_valid SHALL overwrite config; go with cfg_valid=0 SHALL enter RUN_UP; if both are high the same cycle, cfg_valid wins and go is ignored.
REQ-019 On go sampled at edge N, ctrl=cfg_start, gen_rst=1 and the dwell counter loaded with cfg_dwell SHALL all be visible after edge N; gen_rst SHALL be high exactly one cycle.
REQ-020 RUN_UP: counter decrements each cycle; at 0, if ctrl>=cfg_stop or cfg_step=0 the sweep is terminal; otherwise ctrl<=min(ctrl+cfg_step, cfg_stop), computed with a 33-bit sum (never wraps), and the counter is reloaded.
REQ-021 cfg_start>=cfg_stop SHALL give a single dwell at cfg_start, then terminal.
REQ-022 Terminal without SWEEP_BIDIR_EN SHALL go to FIN; FIN SHALL assert done for one cycle, ctrl=0, then go to LOADED with config retained.
REQ-023 busy SHALL be 1 exactly in RUN_UP/RUN_DN; ctrl SHALL be 0 in every other state.
REQ-024 abort in RUN_UP/RUN_DN SHALL take priority over stepping: next cycle ctrl=0, state LOADED, no done pulse; abort in other states ignored.
REQ-025 cfg_valid during RUN SHALL be ignored (cfg_ready=0).

Reset
REQ-026 rst SHALL give state IDLE, ctrl=0, gen_rst=0, busy=0, done=0, cfg_ready=1, config registers and counter = 0.
REQ-027 rst mid-sweep SHALL take effect on the next edge with no done pulse and override all other inputs.

Configuration
REQ-028 Macro SWEEP_BIDIR_EN defined: at the RUN_UP terminal point the block SHALL enter RUN_DN with counter reloaded, stepping ctrl<=max(ctrl-cfg_step, cfg_start) (no underflow), and SHALL go to FIN after the dwell of ctrl<=cfg_start ends; cfg_step=0 or cfg_start>=cfg_stop SHALL skip RUN_DN.
REQ-029 Macro undefined: RUN_DN SHALL not exist; sweep is up-only per REQ-022.

Verification
REQ-030 Reset: rst high 2 cycles -> ctrl=0, busy=0, done=0, gen_rst=0, cfg_ready=1.
REQ-031 start=100, stop=400, step=100, dwell=2, go -> ctrl 100,200,300,400 each 3 cycles, busy 12 cycles, gen_rst on the first, done one cycle after.
REQ-032 Clamp/overflow: start=0, stop=250, step=100, dwell=0 -> 0,100,200,250 then done; start=0xFFFFFF00, stop=0xFFFFFFFF, step=0x80 -> 0xFFFFFF00,0xFFFFFF80,0xFFFFFFFF, done, no wrap.
REQ-033 Abort: REQ-031 config, abort during ctrl=200 -> next cycle ctrl=0, busy=0, no done, cfg_ready=1; later go restarts at 100 with gen_rst.
REQ-034 Same-cycle cfg_valid+go in LOADED -> new config latched, no sweep; go one cycle later sweeps with new config.
REQ-035 start=100, stop=300, step=100, dwell=0 -> with SWEEP_BIDIR_EN: 100,200,300,200,100, done; without: 100,200,300, done.

Source files
------------

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer that steps a control word from start to stop, holding each word for a programmable dwell.
// Optional macro SWEEP_BIDIR_EN adds a descending leg back to the start word before completion.
`timescale 1ns/1ps
module sweep_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [31:0]        cfg_start,
    input  logic [31:0]        cfg_stop,
    input  logic [31:0]        cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               go,
    input  logic               abort,
    output logic [31:0]        ctrl,
    output logic               gen_rst,
    output logic               busy,
    output logic               done
);

`ifdef SWEEP_BIDIR_EN
    typedef enum logic [2:0] {IDLE, LOADED, RUN_UP, RUN_DN, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOADED, RUN_UP, FIN} state_t;
`endif

    state_t               state, state_next;
    logic [31:0]          start_r, stop_r, step_r;
    logic [DWELL_W-1:0]   dwell_r;
    logic [DWELL_W-1:0]   cnt, cnt_next;
    logic [31:0]          ctrl_next;
    logic                 gen_rst_next;
    logic                 load;

    // Upward step is formed in 33 bits so a large step clamps to stop instead of wrapping.
    logic [32:0]          up_sum;
    logic [31:0]          up_word;
    logic                 up_end;

    assign up_sum  = {1'b0, ctrl} + {1'b0, step_r};
    assign up_word = (up_sum > {1'b0, stop_r}) ? stop_r : up_sum[31:0];
    assign up_end  = (ctrl >= stop_r) || (step_r == '0);

`ifdef SWEEP_BIDIR_EN
    logic [32:0]          dn_diff;
    logic [31:0]          dn_word;
    logic                 dn_end;
    logic                 dn_skip;

    assign dn_diff = {1'b0, ctrl} - {1'b0, step_r};
    assign dn_word = (dn_diff[32] || (dn_diff[31:0] < start_r)) ? start_r : dn_diff[31:0];
    assign dn_end  = (ctrl <= start_r);
    assign dn_skip = (step_r == '0) || (start_r >= stop_r);
`endif

    always_comb begin
        state_next   = state;
        ctrl_next    = '0;
        cnt_next     = cnt;
        gen_rst_next = 1'b0;
        load         = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    load       = 1'b1;
                    state_next = LOADED;
                end
            end
            LOADED: begin
                if (cfg_valid) begin
                    load = 1'b1;
                end else if (go) begin
                    state_next   = RUN_UP;
                    ctrl_next    = start_r;
                    cnt_next     = dwell_r;
                    gen_rst_next = 1'b1;
                end
            end
            RUN_UP: begin
                ctrl_next = ctrl;
                if (abort) begin
                    state_next = LOADED;
                    ctrl_next  = '0;
                end else if (cnt != '0) begin
                    cnt_next = cnt - DWELL_W'(1);
                end else if (up_end) begin
`ifdef SWEEP_BIDIR_EN
                    if (dn_skip) begin
                        state_next = FIN;
                        ctrl_next  = '0;
                    end else begin
                        state_next = RUN_DN;
                        ctrl_next  = dn_word;
                        cnt_next   = dwell_r;
                    end
`else
                    state_next = FIN;
                    ctrl_next  = '0;
`endif
                end else begin
                    ctrl_next = up_word;
                    cnt_next  = dwell_r;
                end
            end
`ifdef SWEEP_BIDIR_EN
            RUN_DN: begin
                ctrl_next = ctrl;
                if (abort) begin
                    state_next = LOADED;
                    ctrl_next  = '0;
                end else if (cnt != '0) begin
                    cnt_next = cnt - DWELL_W'(1);
                end else if (dn_end) begin
                    state_next = FIN;
                    ctrl_next  = '0;
                end else begin
                    ctrl_next = dn_word;
                    cnt_next  = dwell_r;
                end
            end
`endif
            FIN: begin
                state_next = LOADED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ctrl    <= '0;
            gen_rst <= 1'b0;
            cnt     <= '0;
            start_r <= '0;
            stop_r  <= '0;
            step_r  <= '0;
            dwell_r <= '0;
        end else begin
            state   <= state_next;
            ctrl    <= ctrl_next;
            gen_rst <= gen_rst_next;
            cnt     <= cnt_next;
            if (load) begin
                start_r <= cfg_start;
                stop_r  <= cfg_stop;
                step_r  <= cfg_step;
                dwell_r <= cfg_dwell;
            end
        end
    end

    assign cfg_ready = (state == IDLE) || (state == LOADED);
`ifdef SWEEP_BIDIR_EN
    assign busy      = (state == RUN_UP) || (state == RUN_DN);
`else
    assign busy      = (state == RUN_UP);
`endif
    assign done      = (state == FIN);

endmodule

// File: tb/tb_sweep_ctrl.sv
// Randomized bench for sweep_ctrl: each sweep is predicted as a per-cycle word list from the sweep rules.
// Honors SWEEP_BIDIR_EN the same way as the design.
`timescale 1ns/1ps
module tb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_start, cfg_stop, cfg_step;
    logic [15:0] cfg_dwell;
    logic        go, abort;
    logic [31:0] ctrl;
    logic        gen_rst, busy, done;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [31:0] m_start, m_stop, m_step;
    logic [15:0] m_dwell;
    logic [31:0] exp_q[$];

    sweep_ctrl #(.DWELL_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
        .go(go), .abort(abort), .ctrl(ctrl), .gen_rst(gen_rst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word list for one sweep, one entry per busy cycle.
    function automatic void build_expected();
        longint w;
        exp_q.delete();
        w = longint'(m_start);
        forever begin
            for (int d = 0; d <= int'(m_dwell); d++) exp_q.push_back(w[31:0]);
            if (w >= longint'(m_stop) || m_step == 0) break;
            w = w + longint'(m_step);
            if (w > longint'(m_stop)) w = longint'(m_stop);
        end
`ifdef SWEEP_BIDIR_EN
        if (m_step != 0 && m_start < m_stop) begin
            forever begin
                w = w - longint'(m_step);
                if (w < longint'(m_start)) w = longint'(m_start);
                for (int d = 0; d <= int'(m_dwell); d++) exp_q.push_back(w[31:0]);
                if (w <= longint'(m_start)) break;
            end
        end
`endif
    endfunction

    task automatic load_cfg(input logic [31:0] s, input logic [31:0] p,
                            input logic [31:0] st, input logic [15:0] d);
        cfg_valid = 1'b1;
        cfg_start = s; cfg_stop = p; cfg_step = st; cfg_dwell = d;
        tick();
        cfg_valid = 1'b0;
        m_start = s; m_stop = p; m_step = st; m_dwell = d;
        check("load_ready", {31'b0, cfg_ready}, 32'd1);
        check("load_busy", {31'b0, busy}, 32'd0);
        check("load_ctrl", ctrl, 32'd0);
    endtask

    task automatic run_sweep(input bit do_abort, input bit noise);
        int abort_at;
        int n;
        build_expected();
        n = exp_q.size();
        abort_at = do_abort ? int'($urandom_range(0, n - 1)) : -1;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 0; k < n; k++) begin
            check("run_ctrl", ctrl, exp_q[k]);
            check("run_busy", {31'b0, busy}, 32'd1);
            check("run_gen_rst", {31'b0, gen_rst}, (k == 0) ? 32'd1 : 32'd0);
            check("run_done", {31'b0, done}, 32'd0);
            check("run_ready", {31'b0, cfg_ready}, 32'd0);
            if (noise) begin
                cfg_valid = $urandom_range(0, 1) == 1;
                cfg_start = $urandom; cfg_stop = $urandom;
                cfg_step = $urandom; cfg_dwell = 16'($urandom);
            end
            if (k == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                cfg_valid = 1'b0;
                check("abort_ctrl", ctrl, 32'd0);
                check("abort_busy", {31'b0, busy}, 32'd0);
                check("abort_done", {31'b0, done}, 32'd0);
                check("abort_ready", {31'b0, cfg_ready}, 32'd1);
                tick();
                check("abort_done2", {31'b0, done}, 32'd0);
                return;
            end
            tick();
            cfg_valid = 1'b0;
        end
        check("fin_done", {31'b0, done}, 32'd1);
        check("fin_ctrl", ctrl, 32'd0);
        check("fin_busy", {31'b0, busy}, 32'd0);
        check("fin_gen_rst", {31'b0, gen_rst}, 32'd0);
        tick();
        check("post_done", {31'b0, done}, 32'd0);
        check("post_ready", {31'b0, cfg_ready}, 32'd1);
        check("post_ctrl", ctrl, 32'd0);
    endtask

    task automatic random_cfg();
        longint s, p;
        logic [31:0] st;
        case ($urandom_range(0, 3))
            0: begin
                s = longint'($urandom_range(0, 100000));
                p = s + longint'($urandom_range(0, 2000));
                st = $urandom_range(100, 600);
            end
            1: begin
                s = longint'(32'hFFFF_F000) + longint'($urandom_range(0, 32'hF00));
                p = longint'(32'hFFFF_FFFF);
                st = $urandom_range(150, 1000);
            end
            2: begin
                p = longint'($urandom_range(0, 5000));
                s = p + longint'($urandom_range(0, 5000));
                st = $urandom_range(0, 300);
            end
            default: begin
                s = longint'($urandom_range(0, 3000));
                p = s + longint'($urandom_range(0, 1500));
                st = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 900));
            end
        endcase
        load_cfg(s[31:0], p[31:0], st, 16'($urandom_range(0, 3)));
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; go = 1'b0; abort = 1'b0;
        cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0;
        tick();
        tick();
        check("rst_ctrl", ctrl, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_gen_rst", {31'b0, gen_rst}, 32'd0);
        check("rst_ready", {31'b0, cfg_ready}, 32'd1);
        rst = 1'b0;

        go = 1'b1; abort = 1'b1;
        tick();
        go = 1'b0; abort = 1'b0;
        check("idle_go_busy", {31'b0, busy}, 32'd0);
        check("idle_go_gen_rst", {31'b0, gen_rst}, 32'd0);

        load_cfg(32'd100, 32'd400, 32'd100, 16'd2);
        run_sweep(1'b0, 1'b0);

        load_cfg(32'd0, 32'd250, 32'd100, 16'd0);
        run_sweep(1'b0, 1'b0);
        load_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd0);
        run_sweep(1'b0, 1'b0);

        // Abort while ctrl=200 (cycles 3..5 of the 100..400 sweep).
        load_cfg(32'd100, 32'd400, 32'd100, 16'd2);
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("pre_abort_ctrl", ctrl, 32'd200);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort200_ctrl", ctrl, 32'd0);
        check("abort200_busy", {31'b0, busy}, 32'd0);
        check("abort200_done", {31'b0, done}, 32'd0);
        check("abort200_ready", {31'b0, cfg_ready}, 32'd1);
        tick();
        check("abort200_done2", {31'b0, done}, 32'd0);
        run_sweep(1'b0, 1'b0);

        // cfg_valid and go together: config wins, no sweep.
        cfg_valid = 1'b1; go = 1'b1;
        cfg_start = 32'd50; cfg_stop = 32'd150; cfg_step = 32'd50; cfg_dwell = 16'd1;
        tick();
        cfg_valid = 1'b0; go = 1'b0;
        m_start = 32'd50; m_stop = 32'd150; m_step = 32'd50; m_dwell = 16'd1;
        check("both_busy", {31'b0, busy}, 32'd0);
        check("both_gen_rst", {31'b0, gen_rst}, 32'd0);
        check("both_ready", {31'b0, cfg_ready}, 32'd1);
        run_sweep(1'b0, 1'b0);

        load_cfg(32'd100, 32'd300, 32'd100, 16'd0);
        run_sweep(1'b0, 1'b0);
        load_cfg(32'd500, 32'd100, 32'd10, 16'd1);
        run_sweep(1'b0, 1'b0);
        load_cfg(32'd5, 32'd100, 32'd0, 16'd0);
        run_sweep(1'b0, 1'b0);

        // Reset mid-sweep overrides every other input.
        load_cfg(32'd100, 32'd400, 32'd100, 16'd2);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        rst = 1'b1; go = 1'b1; abort = 1'b1; cfg_valid = 1'b1;
        tick();
        rst = 1'b0; go = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
        check("mrst_ctrl", ctrl, 32'd0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_done", {31'b0, done}, 32'd0);
        check("mrst_gen_rst", {31'b0, gen_rst}, 32'd0);
        check("mrst_ready", {31'b0, cfg_ready}, 32'd1);
        tick();
        check("mrst_done2", {31'b0, done}, 32'd0);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("mrst_idle_go", {31'b0, busy}, 32'd0);

        for (int t = 0; t < 40; t++) begin
            random_cfg();
            run_sweep($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
